id_stage_pipe: RTL and testbench

- Parametrised, registered RISC-V RV32I decode stage. Sits between the IF/ID register and EX.
- Decodes the instruction and resolves operands through NUM_FWD prioritised forwarding sources.
- Detects load-use hazards and inserts bubbles.
- Presents results through a valid/ready-handshaked ID/EX output register, with flush support and a saturating stall counter.

---
 rtl/rv_decode_pkg.sv | 53 +++++
 rtl/id_decoder.sv | 108 ++++++++++
 rtl/id_stage_pipe.sv | 187 ++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_decode_pkg.sv
// RV32I decode constants and encodings shared by the ID stage and its decoder.
package rv_decode_pkg;
  localparam int XLEN_DEF = 32;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR = 3'b100, F3_SR  = 3'b101, F3_OR  = 3'b110, F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000, F3_BNE = 3'b001, F3_BLT = 3'b100, F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110, F3_BGEU = 3'b111;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS2
  } aluop_e;

  typedef enum logic [2:0] {SEL_NOP, SEL_ALU, SEL_LSU, SEL_BRU} alusel_e;

  // Branch ctrl reuses funct3; 010/011 are unused branch codes.
  localparam logic [2:0] CTRL_NOP  = 3'b010;
  localparam logic [2:0] CTRL_JUMP = 3'b011;

  localparam logic [3:0] W_NONE = 4'b0000;
  localparam logic [3:0] W_LB = 4'b0001, W_LH = 4'b0010, W_LW = 4'b0100;
  localparam logic [3:0] W_LBU = 4'b0101, W_LHU = 4'b0110;
  localparam logic [3:0] W_SB = 4'b1001, W_SH = 4'b1010, W_SW = 4'b1100;

  typedef enum logic {ST_RUN, ST_STALL} state_e;

  function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  alu_f3 = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_f3 = ALU_SLL;
      F3_SLT:  alu_f3 = ALU_SLT;
      F3_SLTU: alu_f3 = ALU_SLTU;
      F3_XOR:  alu_f3 = ALU_XOR;
      F3_SR:   alu_f3 = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_f3 = ALU_OR;
      default: alu_f3 = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/id_decoder.sv
// Combinational RV32I field/immediate decoder for the ID stage.
module id_decoder
  import rv_decode_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic            rs1_used_o,
  output logic            rs2_used_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] off_o,
  output logic            op1_pc_o,
  output logic            op2_imm_o,
  output logic            is_br_o,
  output logic            is_jal_o,
  output logic            is_jalr_o,
  output logic            rd_we_o,
  output logic [3:0]      aluop_o,
  output logic [2:0]      alusel_o,
  output logic [2:0]      ctrl_o,
  output logic [3:0]      width_o,
  output logic            illegal_o
);
  logic [6:0] opc;
  logic [2:0] f3;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] link;

  assign opc   = inst_i[6:0];
  assign f3    = inst_i[14:12];
  assign rs1_o = inst_i[19:15];
  assign rs2_o = inst_i[24:20];
  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'b0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign link  = pc_i + XLEN'(4);

  always_comb begin
    rs1_used_o = 1'b0; rs2_used_o = 1'b0; imm_o = '0; off_o = '0;
    op1_pc_o = 1'b0; op2_imm_o = 1'b0; is_br_o = 1'b0; is_jal_o = 1'b0; is_jalr_o = 1'b0;
    rd_we_o = 1'b0; aluop_o = ALU_ADD; alusel_o = SEL_NOP; ctrl_o = CTRL_NOP;
    width_o = W_NONE; illegal_o = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        rd_we_o = 1'b1; imm_o = XLEN'(imm_u); op2_imm_o = 1'b1; alusel_o = SEL_ALU;
        op1_pc_o = (opc == OPC_AUIPC);
      end
      OPC_JAL, OPC_JALR: begin
        rd_we_o = 1'b1; imm_o = link; op2_imm_o = 1'b1;
        aluop_o = ALU_PASS2; alusel_o = SEL_BRU; ctrl_o = CTRL_JUMP;
        is_jal_o   = (opc == OPC_JAL);
        is_jalr_o  = (opc == OPC_JALR);
        rs1_used_o = (opc == OPC_JALR);
        off_o      = (opc == OPC_JAL) ? XLEN'(imm_j) : XLEN'(imm_i);
      end
      OPC_BRANCH: begin
        rs1_used_o = 1'b1; rs2_used_o = 1'b1; imm_o = XLEN'(imm_b); off_o = XLEN'(imm_b);
        is_br_o = 1'b1; aluop_o = ALU_SUB; alusel_o = SEL_BRU; ctrl_o = f3;
        illegal_o = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        rs1_used_o = 1'b1; rd_we_o = 1'b1; imm_o = XLEN'(imm_i); op2_imm_o = 1'b1;
        alusel_o = SEL_LSU;
        case (f3)
          3'b000:  width_o = W_LB;
          3'b001:  width_o = W_LH;
          3'b010:  width_o = W_LW;
          3'b100:  width_o = W_LBU;
          3'b101:  width_o = W_LHU;
          default: illegal_o = 1'b1;
        endcase
      end
      OPC_STORE: begin
        rs1_used_o = 1'b1; rs2_used_o = 1'b1; imm_o = XLEN'(imm_s); alusel_o = SEL_LSU;
        case (f3)
          3'b000:  width_o = W_SB;
          3'b001:  width_o = W_SH;
          3'b010:  width_o = W_SW;
          default: illegal_o = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        rs1_used_o = 1'b1; rd_we_o = 1'b1; op2_imm_o = 1'b1; alusel_o = SEL_ALU;
        aluop_o = alu_f3(f3, (f3 == F3_SR) && inst_i[30]);
        imm_o = (f3 == F3_SLL || f3 == F3_SR) ? XLEN'(inst_i[24:20]) : XLEN'(imm_i);
      end
      OPC_OP: begin
        rs1_used_o = 1'b1; rs2_used_o = 1'b1; rd_we_o = 1'b1; alusel_o = SEL_ALU;
        aluop_o = alu_f3(f3, inst_i[30]);
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: illegal_o = 1'b1;
    endcase
    // Illegal encodings leave the pipe as a harmless NOP carrying the flag.
    if (illegal_o) begin
      rs1_used_o = 1'b0; rs2_used_o = 1'b0; imm_o = '0; off_o = '0;
      op1_pc_o = 1'b0; op2_imm_o = 1'b0; is_br_o = 1'b0; is_jal_o = 1'b0; is_jalr_o = 1'b0;
      rd_we_o = 1'b0; aluop_o = ALU_ADD; alusel_o = SEL_NOP; ctrl_o = CTRL_NOP; width_o = W_NONE;
    end
    rd_o = rd_we_o ? inst_i[11:7] : 5'd0;
  end
endmodule

// File: rtl/id_stage_pipe.sv
// RV32I decode stage: forwarding, load-use stall, ID/EX register with handshake.
// Define ID_EARLY_BRANCH_EN to resolve branches/jumps in ID and emit a redirect pulse.
module id_stage_pipe
  import rv_decode_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int NUM_FWD     = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [31:0]             in_inst,
  input  logic [XLEN-1:0]         in_pred,
  output logic [4:0]              rs1_addr,
  output logic [4:0]              rs2_addr,
  input  logic [XLEN-1:0]         rs1_data,
  input  logic [XLEN-1:0]         rs2_data,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [5*NUM_FWD-1:0]    fwd_addr,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic                    ex_load_valid,
  input  logic [4:0]              ex_load_rd,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_pred,
  output logic [XLEN-1:0]         out_op1,
  output logic [XLEN-1:0]         out_op2,
  output logic [XLEN-1:0]         out_imm,
  output logic [4:0]              out_rd,
  output logic                    out_rd_we,
  output logic [3:0]              out_aluop,
  output logic [2:0]              out_alusel,
  output logic [2:0]              out_ctrl,
  output logic [3:0]              out_width,
  output logic [XLEN-1:0]         out_jmp_addr,
  output logic                    out_illegal,
  output logic                    redirect_valid,
  output logic [XLEN-1:0]         redirect_pc,
  output logic [STALL_CNT_W-1:0]  stall_cycles
);
  logic [4:0] d_rs1, d_rs2, d_rd;
  logic d_rs1_used, d_rs2_used, d_op1_pc, d_op2_imm, d_is_br, d_is_jal, d_is_jalr, d_rd_we, d_illegal;
  logic [XLEN-1:0] d_imm, d_off;
  logic [3:0] d_aluop, d_width;
  logic [2:0] d_alusel, d_ctrl, ctrl_d;

  id_decoder #(.XLEN(XLEN)) u_dec (
    .inst_i(in_inst), .pc_i(in_pc), .rs1_o(d_rs1), .rs2_o(d_rs2), .rd_o(d_rd),
    .rs1_used_o(d_rs1_used), .rs2_used_o(d_rs2_used), .imm_o(d_imm), .off_o(d_off),
    .op1_pc_o(d_op1_pc), .op2_imm_o(d_op2_imm), .is_br_o(d_is_br), .is_jal_o(d_is_jal),
    .is_jalr_o(d_is_jalr), .rd_we_o(d_rd_we), .aluop_o(d_aluop), .alusel_o(d_alusel),
    .ctrl_o(d_ctrl), .width_o(d_width), .illegal_o(d_illegal)
  );

  assign rs1_addr = d_rs1;
  assign rs2_addr = d_rs2;

  // Descending scan so the lowest (youngest) matching source wins.
  logic [XLEN-1:0] rs1_val, rs2_val, op1_d, op2_d, jalr_sum, jmp_d;
  always_comb begin
    rs1_val = rs1_data;
    rs2_val = rs2_data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_addr[i*5 +: 5] == d_rs1) rs1_val = fwd_data[i*XLEN +: XLEN];
      if (fwd_valid[i] && fwd_addr[i*5 +: 5] == d_rs2) rs2_val = fwd_data[i*XLEN +: XLEN];
    end
    if (!d_rs1_used || d_rs1 == 5'd0) rs1_val = '0;
    if (!d_rs2_used || d_rs2 == 5'd0) rs2_val = '0;
    op1_d    = d_op1_pc ? in_pc : rs1_val;
    op2_d    = d_op2_imm ? d_imm : rs2_val;
    jalr_sum = rs1_val + d_off;
    if (d_is_jalr)                 jmp_d = {jalr_sum[XLEN-1:1], 1'b0};
    else if (d_is_jal || d_is_br)  jmp_d = in_pc + d_off;
    else                           jmp_d = '0;
  end

  logic hazard, load_en, fire;
  logic out_valid_q;
  assign hazard = ex_load_valid && ex_load_rd != 5'd0 &&
                  ((d_rs1_used && d_rs1 == ex_load_rd) || (d_rs2_used && d_rs2 == ex_load_rd));
  assign load_en  = !out_valid_q || out_ready;
  assign in_ready = load_en && !hazard && !flush;
  assign fire     = in_valid && in_ready;

  state_e state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (in_valid && hazard && !flush) state_d = ST_STALL;
      ST_STALL: if (!hazard || flush) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_STALL && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end
  assign stall_cycles = stall_q;

`ifdef ID_EARLY_BRANCH_EN
  logic taken, mispred, redir_q;
  logic [XLEN-1:0] next_pc, redir_pc_q;
  always_comb begin
    case (in_inst[14:12])
      F3_BEQ:  taken = rs1_val == rs2_val;
      F3_BNE:  taken = rs1_val != rs2_val;
      F3_BLT:  taken = $signed(rs1_val) <  $signed(rs2_val);
      F3_BGE:  taken = $signed(rs1_val) >= $signed(rs2_val);
      F3_BLTU: taken = rs1_val <  rs2_val;
      F3_BGEU: taken = rs1_val >= rs2_val;
      default: taken = 1'b0;
    endcase
    next_pc = (d_is_jal || d_is_jalr || (d_is_br && taken)) ? jmp_d : in_pc + XLEN'(4);
    mispred = (d_is_br || d_is_jal || d_is_jalr) && next_pc != in_pred;
  end
  assign ctrl_d = d_is_br ? CTRL_NOP : d_ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      redir_q <= fire && mispred;
      if (fire && mispred) redir_pc_q <= next_pc;
    end
  end
  assign redirect_valid = redir_q;
  assign redirect_pc    = redir_pc_q;
`else
  assign ctrl_d         = d_ctrl;
  assign redirect_valid = 1'b0;
  assign redirect_pc    = '0;
`endif

  logic [XLEN-1:0] pc_q, pred_q, op1_q, op2_q, imm_q, jmp_q;
  logic [4:0] rd_q;
  logic rd_we_q, illegal_q;
  logic [3:0] aluop_q, width_q;
  logic [2:0] alusel_q, ctrl_q;

  // Flush kills the output even while EX is back-pressuring.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      pc_q <= '0; pred_q <= '0; op1_q <= '0; op2_q <= '0; imm_q <= '0; jmp_q <= '0;
      rd_q <= '0; rd_we_q <= 1'b0; illegal_q <= 1'b0;
      aluop_q <= '0; width_q <= '0; alusel_q <= '0; ctrl_q <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (load_en) begin
      out_valid_q <= fire;
      if (fire) begin
        pc_q <= in_pc; pred_q <= in_pred; op1_q <= op1_d; op2_q <= op2_d; imm_q <= d_imm;
        jmp_q <= jmp_d; rd_q <= d_rd; rd_we_q <= d_rd_we; illegal_q <= d_illegal;
        aluop_q <= d_aluop; width_q <= d_width; alusel_q <= d_alusel; ctrl_q <= ctrl_d;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = pc_q;
  assign out_pred     = pred_q;
  assign out_op1      = op1_q;
  assign out_op2      = op2_q;
  assign out_imm      = imm_q;
  assign out_rd       = rd_q;
  assign out_rd_we    = rd_we_q;
  assign out_aluop    = aluop_q;
  assign out_alusel   = alusel_q;
  assign out_ctrl     = ctrl_q;
  assign out_width    = width_q;
  assign out_jmp_addr = jmp_q;
  assign out_illegal  = illegal_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed-vector bench for id_stage_pipe with hand-encoded RV32I instructions.
module tb_id_stage_pipe;
  import rv_decode_pkg::*;
  localparam int XLEN = 32, NUM_FWD = 2, SCW = 16;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, ex_load_valid, flush, out_valid, out_ready;
  logic [XLEN-1:0] in_pc, in_pred, rs1_data, rs2_data;
  logic [31:0] in_inst;
  logic [4:0] rs1_addr, rs2_addr, ex_load_rd, out_rd;
  logic [NUM_FWD-1:0] fwd_valid;
  logic [5*NUM_FWD-1:0] fwd_addr;
  logic [XLEN*NUM_FWD-1:0] fwd_data;
  logic [XLEN-1:0] out_pc, out_pred, out_op1, out_op2, out_imm, out_jmp_addr, redirect_pc;
  logic out_rd_we, out_illegal, redirect_valid;
  logic [3:0] out_aluop, out_width;
  logic [2:0] out_alusel, out_ctrl;
  logic [SCW-1:0] stall_cycles;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .STALL_CNT_W(SCW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .in_pred(in_pred), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pred(out_pred), .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_aluop(out_aluop), .out_alusel(out_alusel),
    .out_ctrl(out_ctrl), .out_width(out_width), .out_jmp_addr(out_jmp_addr),
    .out_illegal(out_illegal), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_cycles(stall_cycles)
  );

  int n_run = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] pred);
    in_valid = 1'b1; in_pc = pc; in_inst = inst; in_pred = pred;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; in_pred = '0;
    rs1_data = 32'hA1; rs2_data = 32'hB2; fwd_valid = '0; fwd_addr = '0; fwd_data = '0;
    ex_load_valid = 1'b0; ex_load_rd = '0; flush = 1'b0; out_ready = 1'b1;
    drive(32'h100, 32'h00500093, 32'h104);
    repeat (2) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_redir_v", redirect_valid, 0);
    chk("rst_redir_pc", redirect_pc, 0);
    rst = 1'b0;

    // ADDI x1,x0,5
    #1 chk("addi_rdy", in_ready, 1);
    tick();
    chk("addi_valid", out_valid, 1);
    chk("addi_op1", out_op1, 0);
    chk("addi_op2", out_op2, 5);
    chk("addi_rd", out_rd, 1);
    chk("addi_we", out_rd_we, 1);
    chk("addi_ill", out_illegal, 0);

    // ADD x3,x1,x2 with both sources on x1: youngest wins
    fwd_valid = 2'b11; fwd_addr = {5'd1, 5'd1}; fwd_data = {32'h22, 32'h11};
    drive(32'h104, 32'h002081B3, 32'h108);
    tick();
    chk("add_fwd0_op1", out_op1, 32'h11);
    chk("add_fwd0_op2", out_op2, 32'hB2);
    chk("add_rd", out_rd, 3);
    chk("add_rs1a", rs1_addr, 1);
    chk("add_rs2a", rs2_addr, 2);
    fwd_valid = 2'b01; fwd_addr = {5'd1, 5'd0};
    tick();
    chk("add_fwdx0_op1", out_op1, 32'hA1);
    fwd_valid = 2'b11; fwd_addr = {5'd1, 5'd2};
    tick();
    chk("add_fwd1_op1", out_op1, 32'h22);
    chk("add_fwd0_op2", out_op2, 32'h11);
    fwd_valid = '0;

    // Load-use on x3: ADD x4,x3,x3
    ex_load_valid = 1'b1; ex_load_rd = 5'd3;
    drive(32'h110, 32'h00318233, 32'h114);
    #1 chk("lu_rdy_a", in_ready, 0);
    tick();
    chk("lu_valid_a", out_valid, 0);
    chk("lu_rdy_b", in_ready, 0);
    tick();
    ex_load_valid = 1'b0;
    #1 chk("lu_rdy_c", in_ready, 1);
    chk("lu_valid_b", out_valid, 0);
    chk("lu_stall_1", stall_cycles, 1);
    tick();
    chk("lu_issue_v", out_valid, 1);
    chk("lu_issue_rd", out_rd, 4);
    chk("lu_issue_pc", out_pc, 32'h110);
    chk("lu_stall_2", stall_cycles, 2);

    // ADDI x7,x0,-1 then hold EX off for 3 cycles
    drive(32'h118, 32'hFFF00393, 32'h11C);
    tick();
    chk("neg_imm", out_imm, 32'hFFFFFFFF);
    chk("neg_op2", out_op2, 32'hFFFFFFFF);
    out_ready = 1'b0;
    drive(32'h11C, 32'h123452B7, 32'h120);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_rdy", in_ready, 0);
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_rd", out_rd, 7);
      chk("bp_pc", out_pc, 32'h118);
    end
    out_ready = 1'b1;
    #1 chk("bp_rel_rdy", in_ready, 1);
    tick();
    chk("lui_rd", out_rd, 5);
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_op1", out_op1, 0);
    chk("lui_op2", out_op2, 32'h12345000);

    // Flush beats hazard and a stalled EX
    out_ready = 1'b0; ex_load_valid = 1'b1; ex_load_rd = 5'd3; flush = 1'b1;
    drive(32'h120, 32'h00318233, 32'h124);
    #1 chk("fl_rdy", in_ready, 0);
    tick();
    chk("fl_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0; ex_load_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("fl_dropped", out_valid, 0);
    chk("fl_run_stall", stall_cycles, 2);

    // SRAI x6,x1,3
    drive(32'h200, 32'h4030D313, 32'h204);
    tick();
    chk("srai_imm", out_imm, 3);
    chk("srai_op1", out_op1, 32'hA1);
    chk("srai_aluop", out_aluop, ALU_SRA);

    // SW x2,8(x1)
    drive(32'h204, 32'h0020A423, 32'h208);
    tick();
    chk("sw_we", out_rd_we, 0);
    chk("sw_imm", out_imm, 8);
    chk("sw_op2", out_op2, 32'hB2);
    chk("sw_width", out_width, 4'b1100);

    // JALR x1,4(x2) with x2 forwarded
    fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd2}; fwd_data = {32'h0, 32'h3000};
    drive(32'h208, 32'h004100E7, 32'h20C);
    tick();
    chk("jalr_op1", out_op1, 32'h3000);
    chk("jalr_link", out_imm, 32'h20C);
    chk("jalr_op2", out_op2, 32'h20C);
    chk("jalr_tgt", out_jmp_addr, 32'h3004);
    chk("jalr_we", out_rd_we, 1);
    fwd_valid = '0;

    // BEQ x1,x1,+16 at 0x100, predicted not taken
    rs1_data = 32'h55; rs2_data = 32'h55;
    drive(32'h100, 32'h00108863, 32'h104);
    tick();
    chk("beq_tgt", out_jmp_addr, 32'h110);
    chk("beq_we", out_rd_we, 0);
    chk("beq_op2", out_op2, 32'h55);
`ifdef ID_EARLY_BRANCH_EN
    chk("beq_ctrl", out_ctrl, CTRL_NOP);
    chk("beq_redir_v", redirect_valid, 1);
    chk("beq_redir_pc", redirect_pc, 32'h110);
    in_valid = 1'b0;
    tick();
    chk("beq_redir_end", redirect_valid, 0);
`else
    chk("beq_ctrl", out_ctrl, 3'b000);
    chk("beq_redir_v", redirect_valid, 0);
`endif
    rs1_data = 32'hA1; rs2_data = 32'hB2;

    // Opcode 0x7F
    drive(32'h300, 32'hFFFFFFFF, 32'h304);
    tick();
    chk("ill_valid", out_valid, 1);
    chk("ill_flag", out_illegal, 1);
    chk("ill_we", out_rd_we, 0);
    in_valid = 1'b0;
    tick();
    chk("bubble_valid", out_valid, 0);
    chk("bubble_hold_pc", out_pc, 32'h300);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
